// File: rtl/opfetch_pkg.sv
// opfetch_pkg: shared constants and FSM state encoding for operand_fetch_arbiter
package opfetch_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 16;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t READ = 2'd1;
    localparam state_t RESP = 2'd2;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input arbiter picking the winner index among req0/req1
//   req0, req1 : pending requests
//   last_gnt   : index granted last (round-robin history)
//   gnt        : winner index (0 = req0, 1 = req1); only meaningful if a req is high
//   OPFETCH_FIXED_PRIO_EN defined: req0 always wins ties, last_gnt ignored
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt
);
`ifdef OPFETCH_FIXED_PRIO_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
    assign gnt = !req0;
`else
    // on a tie the requester not granted last wins
    assign gnt = (req0 && req1) ? !last_gnt : !req0;
`endif
endmodule

// File: rtl/operand_fetch_arbiter.sv
// operand_fetch_arbiter: arbitrates two requesters onto one operand memory read port
//   clk, rst          : clock, asynchronous active-high reset
//   req0/addr0/ack0   : requester 0 level request, address, one-cycle ack
//   req1/addr1/ack1   : requester 1 level request, address, one-cycle ack
//   rdata             : registered read data, valid with ack0/ack1
//   mem_addr/mem_data : combinational operand memory port
//   busy              : high outside IDLE
//   OPFETCH_FIXED_PRIO_EN selects fixed req0 priority inside rr_arb2
module operand_fetch_arbiter
    import opfetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);
    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              gnt_q;
    logic              last_gnt;
    logic              win;

    rr_arb2 u_arb (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .gnt      (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            gnt_q    <= 1'b0;
            last_gnt <= 1'b1;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    state    <= READ;
                    addr_q   <= win ? addr1 : addr0;
                    gnt_q    <= win;
                    last_gnt <= win;
                end
                READ: begin
                    rdata <= mem_data;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr = addr_q;
    assign busy     = state != IDLE;
    assign ack0     = state == RESP && !gnt_q;
    assign ack1     = state == RESP && gnt_q;
endmodule
